// File: rtl/pmu_quota_scheduler_if.sv
// Bus bundle between the PMU counter/config side and the shared quota scheduler.
// The scheduler takes the slave view. The counter bank and config registers take the master view.
interface pmu_quota_scheduler_if #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned N_COUNTERS = 9,
    parameter int unsigned N_CORES    = 4
);
    localparam int unsigned CORE_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    logic                            softrst_i;
    logic                            en_i;
    logic [N_COUNTERS*REG_WIDTH-1:0] counter_value_i;
    logic [N_CORES*N_COUNTERS-1:0]   quota_mask_i;
    logic [N_CORES*REG_WIDTH-1:0]    quota_limit_i;
    logic [REG_WIDTH-1:0]            period_i;
    logic [N_CORES-1:0]              intr_ack_i;
    logic [N_CORES-1:0]              intr_quota_o;
    logic                            scan_done_o;
    logic [CORE_W-1:0]               cur_core_o;

    modport master (
        output softrst_i, en_i, counter_value_i, quota_mask_i, quota_limit_i,
               period_i, intr_ack_i,
        input  intr_quota_o, scan_done_o, cur_core_o
    );

    modport slave (
        input  softrst_i, en_i, counter_value_i, quota_mask_i, quota_limit_i,
               period_i, intr_ack_i,
        output intr_quota_o, scan_done_o, cur_core_o
    );
endinterface

// File: rtl/pmu_quota_scheduler.sv
// Time-shared PMU quota checker: round-robin sums each core's masked counters and compares them against that core's limit.
// Sticky per-core interrupts are cleared by acknowledge or by the replenish-period timer.
module pmu_quota_scheduler #(
    parameter int unsigned REG_WIDTH  = 32,
    parameter int unsigned N_COUNTERS = 9,
    parameter int unsigned N_CORES    = 4
) (
    input logic                  clk_i,
    input logic                  rstn_i,
    pmu_quota_scheduler_if.slave bus
);
    localparam int unsigned SUM_WIDTH = REG_WIDTH + $clog2(N_COUNTERS);
    localparam int unsigned CORE_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
    localparam int unsigned CNT_W     = (N_COUNTERS > 1) ? $clog2(N_COUNTERS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_COMPARE
    } state_t;

    state_t                state_q;
    logic [CORE_W-1:0]     cur_core_q;
    logic [CNT_W-1:0]      cnt_idx_q;
    logic [SUM_WIDTH-1:0]  sum_q;
    logic [REG_WIDTH-1:0]  timer_q;
    logic [N_COUNTERS-1:0] mask_snap_q;
    logic [N_CORES-1:0]    intr_q;
    logic                  scan_done_q;

    logic [REG_WIDTH-1:0]  cnt_arr  [N_COUNTERS];
    logic [N_COUNTERS-1:0] mask_arr [N_CORES];
    logic [REG_WIDTH-1:0]  lim_arr  [N_CORES];

    // Unflatten the bus vectors so they can be indexed by the scan indices.
    for (genvar k = 0; k < N_COUNTERS; k++) begin : g_cnt
        assign cnt_arr[k] = bus.counter_value_i[k*REG_WIDTH +: REG_WIDTH];
    end
    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        assign mask_arr[c] = bus.quota_mask_i[c*N_COUNTERS +: N_COUNTERS];
        assign lim_arr[c]  = bus.quota_limit_i[c*REG_WIDTH +: REG_WIDTH];
    end

    logic                 replen_c;
    logic                 mask_chg_c;
    logic                 last_cnt_c;
    logic                 last_core_c;
    logic                 over_c;
    logic [N_CORES-1:0]   core_bit_c;
    logic [SUM_WIDTH-1:0] addend_c;

    // >= rather than == so a period shrunk below the running timer fires on the next edge.
    assign replen_c    = bus.en_i && (bus.period_i != '0) &&
                         (timer_q >= (bus.period_i - REG_WIDTH'(1)));
    assign mask_chg_c  = ((state_q == S_ACCUM) || (state_q == S_COMPARE)) &&
                         (mask_arr[cur_core_q] != mask_snap_q);
    assign last_cnt_c  = (cnt_idx_q == CNT_W'(N_COUNTERS - 1));
    assign last_core_c = (cur_core_q == CORE_W'(N_CORES - 1));
    assign over_c      = (sum_q > SUM_WIDTH'(lim_arr[cur_core_q]));
    assign core_bit_c  = N_CORES'(1) << cur_core_q;
    assign addend_c    = mask_snap_q[cnt_idx_q] ? SUM_WIDTH'(cnt_arr[cnt_idx_q]) : '0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cur_core_q  <= '0;
            cnt_idx_q   <= '0;
            sum_q       <= '0;
            timer_q     <= '0;
            mask_snap_q <= '0;
            intr_q      <= '0;
            scan_done_q <= 1'b0;
        end else if (bus.softrst_i) begin
            state_q     <= S_IDLE;
            cur_core_q  <= '0;
            cnt_idx_q   <= '0;
            sum_q       <= '0;
            timer_q     <= '0;
            mask_snap_q <= '0;
            intr_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            scan_done_q <= 1'b0;
            intr_q      <= intr_q & ~bus.intr_ack_i;

            if (bus.en_i && (bus.period_i != '0)) begin
                timer_q <= replen_c ? '0 : timer_q + REG_WIDTH'(1);
            end

            // Replenish overrides the scan, compare result and acknowledge alike.
            if (replen_c) begin
                intr_q     <= '0;
                cur_core_q <= '0;
                state_q    <= S_CLEAR;
            end else if (mask_chg_c) begin
                state_q <= S_CLEAR;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.en_i) state_q <= S_CLEAR;
                    end
                    S_CLEAR: begin
                        sum_q       <= '0;
                        cnt_idx_q   <= '0;
                        mask_snap_q <= mask_arr[cur_core_q];
                        state_q     <= S_ACCUM;
                    end
                    S_ACCUM: begin
                        sum_q <= sum_q + addend_c;
                        if (last_cnt_c) begin
                            state_q <= S_COMPARE;
                        end else begin
                            cnt_idx_q <= cnt_idx_q + CNT_W'(1);
                        end
                    end
                    S_COMPARE: begin
                        // A same-cycle set outranks the acknowledge for this core.
                        if (over_c) intr_q <= (intr_q & ~bus.intr_ack_i) | core_bit_c;
                        if (last_core_c) begin
                            scan_done_q <= 1'b1;
                            cur_core_q  <= '0;
                        end else begin
                            cur_core_q <= cur_core_q + CORE_W'(1);
                        end
                        state_q <= bus.en_i ? S_CLEAR : S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.intr_quota_o = intr_q;
    assign bus.scan_done_o  = scan_done_q;
    assign bus.cur_core_o   = cur_core_q;
endmodule

// File: doc/pmu_quota_scheduler.md
Name: pmu_quota_scheduler

Overview:
- Shares one quota accumulator/comparator between N_CORES cores; replaces per-core PMU quota units.
- Round-robin scans each core's masked sum of the global PMU counters, compares it against that core's limit, and keeps a sticky per-core interrupt.
- A replenish-period timer clears all quota interrupts and restarts the scan, which gives windowed quota enforcement.
- Sits between the PMU counter bank and the PMU configuration registers.

Parameters:
- REG_WIDTH, 32, width of counters, limits and period.
- N_COUNTERS, 9, number of PMU counters shared by all cores.
- N_CORES, 4, number of cores with independent quota.
- SUM_WIDTH (localparam), REG_WIDTH+$clog2(N_COUNTERS), accumulator width; the sum cannot overflow.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- softrst_i  in  1  synchronous soft reset, active high.
- en_i  in  1  scan enable; when low, the FSM holds in IDLE.
- counter_value_i  in  N_COUNTERS*REG_WIDTH  flattened counter values; counter k at [k*REG_WIDTH +: REG_WIDTH].
- quota_mask_i  in  N_CORES*N_COUNTERS  per-core counter masks; core c at [c*N_COUNTERS +: N_COUNTERS].
- quota_limit_i  in  N_CORES*REG_WIDTH  per-core limits.
- period_i  in  REG_WIDTH  replenish period in cycles; 0 disables replenish.
- intr_ack_i  in  N_CORES  write-1-to-clear of intr_quota_o bits.
- intr_quota_o  out  N_CORES  sticky per-core quota interrupts.
- scan_done_o  out  1  one-cycle pulse after the last core's COMPARE.
- cur_core_o  out  $clog2(N_CORES) (min 1)  core currently being scanned.

Behaviour:
- Reset (rstn_i low, async) or softrst_i: FSM goes to IDLE; core index, counter index, sum and period timer go to 0; intr_quota_o=0; scan_done_o=0; cur_core_o=0.
- FSM states:
  - IDLE: if en_i, go to CLEAR next cycle.
  - CLEAR: sum<=0, cnt_idx<=0; latch mask_snap<=mask of cur_core; go to ACCUM.
  - ACCUM: sum <= sum + (mask_snap[cnt_idx] ? zero-extended counter[cnt_idx] : 0); cnt_idx++. After cnt_idx==N_COUNTERS-1 is accumulated, go to COMPARE.
  - COMPARE: if sum > zero-extended limit[cur_core] (strict), set intr bit of cur_core. If cur_core==N_CORES-1, pulse scan_done_o and set cur_core=0, else cur_core++. Go to CLEAR if en_i, else IDLE.
- Latency: exactly N_COUNTERS+2 cycles per core; full scan is N_CORES*(N_COUNTERS+2) cycles. intr_quota_o is registered and asserts the cycle after COMPARE.
- Mask change: if cur_core's live mask differs from mask_snap during ACCUM or COMPARE, abandon that core and go to CLEAR for the same core. No intr update, no index advance.
- en_i low mid-scan: finish the current core through COMPARE, then IDLE. The next enable resumes at the stored cur_core.
- Interrupt stickiness:
  - A bit stays set until intr_ack_i for that bit, replenish, softrst_i or reset.
  - COMPARE set and intr_ack_i on the same core in the same cycle: the set wins.
- Replenish timer:
  - When period_i!=0 and en_i: the timer increments each cycle.
  - When timer==period_i-1: timer<=0, all intr bits clear, and the FSM restarts at CLEAR with cur_core=0. No scan_done_o pulse is issued.
  - Replenish has priority over a same-cycle COMPARE set, ack, or mask restart.
  - A period_i write takes effect immediately. If timer>=period_i-1, replenish fires on the next cycle.
- Counter values are sampled live in ACCUM; counters need not be stable across a scan.
- softrst_i has priority over everything except rstn_i.

Test Plan:
- N_CORES=2, N_COUNTERS=4, counters={10,20,30,40}, mask0=4'b0101, limit0=39, mask1=4'b1111, limit1=100, period=0 -> core0 sum 40, intr[0]=1 the cycle after the first COMPARE at cycle 6. Core1 sum 100 gives no intr (strict >). scan_done_o pulses every 12 cycles.
- Same setup with limit1=99 -> intr=2'b11 after the first scan. Assert intr_ack_i=2'b01 -> intr[0] clears, then re-sets on the next core0 COMPARE. Ack coinciding with core0 COMPARE -> intr[0] stays 1.
- Toggle mask0 to 4'b0001 during core0 ACCUM -> core0 restarts at CLEAR. Sum 10 ≤ 39 -> intr[0] stays 0. Core1 timing is delayed by the restart cycles.
- period=20 with intr=2'b11 set -> at timer 19 all intr clear and the scan restarts at core0 with no scan_done_o pulse. Bits re-set on later COMPAREs.
- All counters=32'hFFFF_FFFF, mask=all-ones, limit=32'hFFFF_FFFF -> sum=4*(2^32-1) fits SUM_WIDTH=34 -> intr set, no wrap.
- Assert rstn_i low mid-ACCUM -> outputs immediately 0, FSM in IDLE. softrst_i mid-scan -> same result on the next edge.
